// File: rtl/memoria_datos_be_if.sv
// Bus between the datapath (master) and the data memory (slave).
//   EscrMem/LeerMem : store / load request
//   Direc           : byte address, ADDR_W bits
//   Datain          : right-justified store data
//   Modo            : access size (00 byte, 01 half, 10 word, 11 illegal)
//   SinSigno        : 1 zero-extend, 0 sign-extend on loads
//   Dataout         : registered load result
//   DataValid       : one-cycle strobe, Dataout updated by a load
//   ErrAlin         : one-cycle strobe, rejected access
//   Ocupado         : memory busy clearing, requests ignored
interface memoria_datos_be_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              EscrMem;
  logic              LeerMem;
  logic [ADDR_W-1:0] Direc;
  logic [31:0]       Datain;
  logic [1:0]        Modo;
  logic              SinSigno;
  logic [31:0]       Dataout;
  logic              DataValid;
  logic              ErrAlin;
  logic              Ocupado;

  modport master (
    output EscrMem, LeerMem, Direc, Datain, Modo, SinSigno,
    input  Dataout, DataValid, ErrAlin, Ocupado
  );

  modport slave (
    input  EscrMem, LeerMem, Direc, Datain, Modo, SinSigno,
    output Dataout, DataValid, ErrAlin, Ocupado
  );
endinterface

// File: rtl/memoria_datos_be.sv
// Data memory with byte/half/word access, sign/zero-extended registered loads,
// alignment/range error strobe and an optional zero sweep of the array after reset.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : memoria_datos_be_if slave (requests in, Dataout/DataValid/ErrAlin/Ocupado out)
module memoria_datos_be #(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  memoria_datos_be_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic [31:0]     dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  // Decoded access
  logic [31:0]     widx_ext;
  logic [IdxW-1:0] acc_idx;
  logic            req_err;
  logic [31:0]     rd_shift;

  // Array write port
  logic [3:0]      we_be;
  logic [IdxW-1:0] we_idx;
  logic [31:0]     we_data;

  assign widx_ext = 32'(bus.Direc[ADDR_W-1:2]);
  assign acc_idx  = IdxW'(widx_ext);
  assign rd_shift = mem[acc_idx] >> {bus.Direc[1:0], 3'b000};

  always_comb begin
    req_err = 1'b0;
    unique case (bus.Modo)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.Direc[0];
      2'b10:   req_err = (bus.Direc[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (widx_ext >= DEPTH) req_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    we_be   = 4'b0000;
    we_idx  = acc_idx;
    we_data = bus.Datain;

    unique case (state_q)
      StClear: begin
        we_be   = 4'b1111;
        we_idx  = cnt_q;
        we_data = '0;
        if (32'(cnt_q) == DEPTH - 1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bus.EscrMem || bus.LeerMem) begin
          if (req_err) begin
            err_d = 1'b1;
          end else if (bus.EscrMem) begin
            // Replicate the field so every enabled lane sees the right bits
            unique case (bus.Modo)
              2'b00: begin
                we_be   = 4'b0001 << bus.Direc[1:0];
                we_data = {4{bus.Datain[7:0]}};
              end
              2'b01: begin
                we_be   = bus.Direc[1] ? 4'b1100 : 4'b0011;
                we_data = {2{bus.Datain[15:0]}};
              end
              default: begin
                we_be   = 4'b1111;
                we_data = bus.Datain;
              end
            endcase
          end else begin
            valid_d = 1'b1;
            unique case (bus.Modo)
              2'b00: dout_d = {{24{~bus.SinSigno & rd_shift[7]}}, rd_shift[7:0]};
              2'b01: dout_d = {{16{~bus.SinSigno & rd_shift[15]}}, rd_shift[15:0]};
              default: dout_d = rd_shift;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; clearing is done by the sweep
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_be[l]) mem[we_idx][8*l +: 8] <= we_data[8*l +: 8];
    end
  end

  assign bus.Dataout   = dout_q;
  assign bus.DataValid = valid_q;
  assign bus.ErrAlin   = err_q;
  assign bus.Ocupado   = (state_q == StClear);

endmodule
